raw_comb_n_streams: RTL
=======================

Name: raw_comb_n_streams

Overview:
- Parametrised successor to the fixed 5-stream raw combiner: accepts the demultiplexed SPI word bus (one-hot stream number + 32-bit bundle) and buffers each of N_STREAMS streams in an internal single-clock FIFO.
- Emits one combined word (16 bits data + 12 bits channel per lane) whenever every enabled lane holds a sample.
- Adds a runtime lane-enable mask, overflow detection, a bad-select flag and a channel-alignment check.
- Sits between the SPI-to-bus CDC stage and the FIR/PCIe path, in the bus_clk domain.

Parameters:
N_STREAMS, 5, number of lanes (1..16)
FIFO_DEPTH, 16, per-lane FIFO depth in words (power of 2, >=4)

Ports:
bus_clk  in  1  sole clock; all logic rising-edge
xike_reset_n  in  1  synchronous, active-low reset
stream_en  in  N_STREAMS  lane enable mask
in_valid  in  1  input word strobe
in_streamno  in  N_STREAMS  one-hot lane select for the input word
in_data  in  32  SPI bundle: [15:0] sample, [28:17] channel number
comb_ready  in  1  downstream ready
comb_valid  out  1  combined word valid
comb_data  out  16*N_STREAMS  lane k sample at [16k+15:16k]
comb_ch  out  12*N_STREAMS  lane k channel at [12k+11:12k]
overflow  out  N_STREAMS  sticky per-lane overflow
bad_sel  out  1  sticky non-one-hot select seen
align_err  out  1  sticky channel-alignment mismatch
clr_flags  in  1  clears sticky flags

Behaviour:
- Reset (xike_reset_n=0 at an edge): all FIFOs empty; comb_valid=0; comb_data=0; comb_ch=0; overflow=0; bad_sel=0; align_err=0.
- Write accept: in_valid=1 and popcount(in_streamno)==1 selects lane k.
  - stream_en[k]=1 and lane not full: push in_data[28:17] and in_data[15:0].
  - stream_en[k]=1 and lane full: word dropped, overflow[k] set.
  - stream_en[k]=0: word silently dropped, no flag.
- in_valid=1 with popcount(in_streamno)!=1: word dropped, bad_sel set.
- Full is count==FIFO_DEPTH. A push to a full lane in the same cycle as a pop of that lane is accepted: no drop, no overflow.
- Disabled lane: FIFO held flushed (count=0) while stream_en[k]=0. Re-enabling starts the lane empty. Mask changes take effect on the next edge.
- Fire condition: stream_en != 0 AND every enabled lane count>=1 AND (comb_valid==0 OR comb_ready==1).
- On fire: pop one word from every enabled lane and load the output register.
  - Enabled lane k: comb_data lane = sample, comb_ch lane = channel.
  - Disabled lane: data 0, channel 0.
  - comb_valid=1.
- No fire while comb_valid=1 and comb_ready=1: comb_valid clears. comb_valid=1 and comb_ready=0: output register holds, no pop (AXI-stream rule; data stable while valid and not ready).
- Throughput: one combined word per cycle when all enabled lanes are non-empty and comb_ready stays high.
- Latency: a word written at edge t is poppable at edge t+1. comb_valid is high after edge t+1 if it completes a set.
- stream_en==0: no fire; comb_valid drains normally.
- Alignment check on each fire: all enabled lanes must carry equal channel[4:0] (same intra-chip index). Any mismatch sets align_err. Data is still output.
- Sticky flags:
  - Cleared by clr_flags=1 at an edge.
  - A set event in the same cycle as clr_flags wins (flag ends at 1).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Mid-operation reset: discards all buffered and output data. comb_valid=0 on the following cycle regardless of comb_ready.

Test Plan:
- Basic round-robin: N=5, all enabled, comb_ready=1.
  - Stimulus: write streams 0..4 in order, with ch=0,32,64,96,128 and samples 0x1000..0x1004.
  - Required: one comb_valid pulse, comb_data={0x1004,0x1003,0x1002,0x1001,0x1000}, comb_ch={128,96,64,32,0}, align_err=0.
- Backpressure: comb_ready=0 for 20 cycles while 3 full rounds are written.
  - Required: first word held stable, no further pops.
  - Then comb_ready=1: 3 words delivered on consecutive cycles in order, overflow=0.
- Overflow: stream 2 disabled-by-starvation, i.e. only lanes 0,1,3,4 written 17 times each with comb_ready=1.
  - Required: overflow=5'b11011 after the 17th write, no comb_valid.
  - Then clr_flags=1: overflow returns to 0.
- Mask: stream_en=5'b00011 and only lanes 0,1 written.
  - Required: comb_valid fires each round; lanes 2..4 read data 0, channel 0.
  - Writes to lane 3 are dropped with no flag.
- Misalignment and bad select:
  - Lane 1 written with ch=33 and lane 0 with ch=0 -> align_err=1.
  - in_valid with in_streamno=5'b00110 -> bad_sel=1, no FIFO count changes.
- Reset mid-stream: xike_reset_n=0 for 1 cycle with comb_valid=1 and lanes half-full.
  - Required: comb_valid=0 and all flags 0 next cycle.
  - A new full round afterwards produces correctly aligned output.

Source files
------------

// File: rtl/raw_comb_n_streams.sv
// ============================================================================
//  Module   : raw_comb_n_streams
//  Purpose  : Buffers N_STREAMS demultiplexed SPI sample streams in per-lane
//             single-clock FIFOs and emits one combined word (16-bit sample
//             plus 12-bit channel per lane) whenever every enabled lane holds
//             a sample. Flags overflow, bad lane selects and channel
//             misalignment across lanes.
//  Ports    : bus_clk       - sole clock, rising edge
//             xike_reset_n  - synchronous active-low reset
//             stream_en     - per-lane enable mask
//             in_valid      - input word strobe
//             in_streamno   - one-hot lane select for the input word
//             in_data       - [15:0] sample, [28:17] channel number
//             comb_ready    - downstream ready
//             comb_valid    - combined word valid
//             comb_data     - lane k sample at [16k+15:16k]
//             comb_ch       - lane k channel at [12k+11:12k]
//             overflow      - sticky per-lane overflow
//             bad_sel       - sticky non-one-hot select seen
//             align_err     - sticky channel alignment mismatch
//             clr_flags     - clears sticky flags
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module raw_comb_n_streams #(
   parameter int N_STREAMS  = 5,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                      bus_clk,
   input  logic                      xike_reset_n,
   input  logic [N_STREAMS-1:0]      stream_en,
   input  logic                      in_valid,
   input  logic [N_STREAMS-1:0]      in_streamno,
   input  logic [31:0]               in_data,
   input  logic                      comb_ready,
   output logic                      comb_valid,
   output logic [16*N_STREAMS-1:0]   comb_data,
   output logic [12*N_STREAMS-1:0]   comb_ch,
   output logic [N_STREAMS-1:0]      overflow,
   output logic                      bad_sel,
   output logic                      align_err,
   input  logic                      clr_flags
);

   localparam int              c_AW   = $clog2(FIFO_DEPTH);
   localparam int              c_CW   = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

   // Stored word layout: [27:16] channel, [15:0] sample
   logic [27:0]               w_rd_word [N_STREAMS];
   logic [N_STREAMS-1:0]      w_nonempty;
   logic [N_STREAMS-1:0]      w_full;
   logic [N_STREAMS-1:0]      w_lane_hit;
   logic [N_STREAMS-1:0]      w_push;
   logic [N_STREAMS-1:0]      w_pop;
   logic [N_STREAMS-1:0]      w_ovf_set;
   logic [4:0]                w_sel_cnt;
   logic                      w_one_hot;
   logic                      w_fire;
   logic                      w_have_ref;
   logic [4:0]                w_ref_ch;
   logic                      w_misalign;
   logic [16*N_STREAMS-1:0]   w_nxt_data;
   logic [12*N_STREAMS-1:0]   w_nxt_ch;
   logic [3:0]                w_unused_bits;

   logic                      r_comb_valid;
   logic [16*N_STREAMS-1:0]   r_comb_data;
   logic [12*N_STREAMS-1:0]   r_comb_ch;
   logic [N_STREAMS-1:0]      r_overflow;
   logic                      r_bad_sel;
   logic                      r_align_err;

   // Bits of the SPI bundle that carry no payload for this block
   assign w_unused_bits = {in_data[31:29], in_data[16]};

   always_comb begin
      w_sel_cnt = '0;
      for (int k = 0; k < N_STREAMS; k++) begin
         w_sel_cnt = w_sel_cnt + 5'(in_streamno[k]);
      end
   end
   assign w_one_hot = (w_sel_cnt == 5'd1);

   // Fire only when every enabled lane can supply a word and the output
   // register is either empty or being consumed this cycle.
   assign w_fire = (|stream_en) &
                   (&(w_nonempty | ~stream_en)) &
                   (~r_comb_valid | comb_ready);
   assign w_pop  = stream_en & {N_STREAMS{w_fire}};

   generate
      for (genvar k = 0; k < N_STREAMS; k++) begin : g_lane
         logic [27:0]      r_mem [FIFO_DEPTH];
         logic [c_AW-1:0]  r_wp;
         logic [c_AW-1:0]  r_rp;
         logic [c_CW-1:0]  r_cnt;

         assign w_nonempty[k] = (r_cnt != '0);
         assign w_full[k]     = (r_cnt == c_FULL);
         assign w_lane_hit[k] = in_valid & w_one_hot & in_streamno[k] & stream_en[k];
         // A pop in the same cycle frees the slot, so a full lane still accepts
         assign w_push[k]     = w_lane_hit[k] & (~w_full[k] | w_pop[k]);
         assign w_ovf_set[k]  = w_lane_hit[k] & w_full[k] & ~w_pop[k];
         assign w_rd_word[k]  = r_mem[r_rp];

         always_ff @(posedge bus_clk) begin
            if (w_push[k]) begin
               r_mem[r_wp] <= {in_data[28:17], in_data[15:0]};
            end
         end

         // A disabled lane is held flushed so re-enabling starts it empty
         always_ff @(posedge bus_clk) begin
            if (!xike_reset_n || !stream_en[k]) begin
               r_wp  <= '0;
               r_rp  <= '0;
               r_cnt <= '0;
            end else begin
               if (w_push[k]) begin
                  r_wp <= r_wp + c_AW'(1);
               end
               if (w_pop[k]) begin
                  r_rp <= r_rp + c_AW'(1);
               end
               case ({w_push[k], w_pop[k]})
                  2'b10:   r_cnt <= r_cnt + c_CW'(1);
                  2'b01:   r_cnt <= r_cnt - c_CW'(1);
                  default: r_cnt <= r_cnt;
               endcase
            end
         end
      end
   endgenerate

   // Alignment reference is the lowest-numbered enabled lane
   always_comb begin
      w_have_ref = 1'b0;
      w_ref_ch   = '0;
      w_misalign = 1'b0;
      for (int k = 0; k < N_STREAMS; k++) begin
         if (stream_en[k]) begin
            if (!w_have_ref) begin
               w_have_ref = 1'b1;
               w_ref_ch   = w_rd_word[k][20:16];
            end else if (w_rd_word[k][20:16] != w_ref_ch) begin
               w_misalign = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_nxt_data = '0;
      w_nxt_ch   = '0;
      for (int k = 0; k < N_STREAMS; k++) begin
         if (stream_en[k]) begin
            w_nxt_data[16*k +: 16] = w_rd_word[k][15:0];
            w_nxt_ch[12*k +: 12]   = w_rd_word[k][27:16];
         end
      end
   end

   // Sticky flags: a set event in the clearing cycle wins
   always_ff @(posedge bus_clk) begin
      if (!xike_reset_n) begin
         r_comb_valid <= 1'b0;
         r_comb_data  <= '0;
         r_comb_ch    <= '0;
         r_overflow   <= '0;
         r_bad_sel    <= 1'b0;
         r_align_err  <= 1'b0;
      end else begin
         if (w_fire) begin
            r_comb_valid <= 1'b1;
            r_comb_data  <= w_nxt_data;
            r_comb_ch    <= w_nxt_ch;
         end else if (comb_ready) begin
            r_comb_valid <= 1'b0;
         end
         r_overflow  <= (clr_flags ? '0 : r_overflow) | w_ovf_set;
         r_bad_sel   <= (clr_flags ? 1'b0 : r_bad_sel) | (in_valid & ~w_one_hot);
         r_align_err <= (clr_flags ? 1'b0 : r_align_err) | (w_fire & w_misalign);
      end
   end

   assign comb_valid = r_comb_valid;
   assign comb_data  = r_comb_data;
   assign comb_ch    = r_comb_ch;
   assign overflow   = r_overflow;
   assign bad_sel    = r_bad_sel;
   assign align_err  = r_align_err;

endmodule

`default_nettype wire
